// File: rtl/reg_bus_initiator_if.sv
// rtl/reg_bus_initiator_if.sv - request, response and register-bus signals of reg_bus_initiator
interface reg_bus_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        reg_cs;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  // master: the initiator itself; slave: host plus responder seen from outside
  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, req_be,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    input  reg_rdata, reg_ack
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, req_be,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
    output reg_rdata, reg_ack
  );
endinterface

// File: rtl/reg_bus_initiator.sv
// rtl/reg_bus_initiator.sv - one-outstanding register bus initiator; ack timeout under REG_INIT_TIMEOUT_EN
module reg_bus_initiator #(
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] TO_RDATA    = 32'hFFFF_FFFF
) (
  input logic                 mclk,
  input logic                 reset,
  reg_bus_initiator_if.master bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        wr_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        ack_hit;
  logic        timeout_hit;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign ack_hit = (state == ACCESS) && bus.reg_ack;

`ifdef REG_INIT_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tcnt;
  logic       err_q;

  // an ack arriving in the expiry cycle still completes the access normally
  assign timeout_hit = (state == ACCESS) && !bus.reg_ack && (tcnt == TO_LAST);

  always_ff @(posedge mclk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (accept) begin
      tcnt <= '0;
    end else if ((state == ACCESS) && !bus.reg_ack) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (ack_hit) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign bus.rsp_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^{TO_RDATA, TIMEOUT_CYC};
  assign timeout_hit = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge mclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = ACCESS;
      ACCESS:  if (ack_hit || timeout_hit) state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.reg_cs    = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE:    bus.req_ready = 1'b1;
      ACCESS:  bus.reg_cs    = 1'b1;
      RESP:    bus.rsp_valid = 1'b1;
      default: bus.req_ready = 1'b0;
    endcase
  end

  // bus fields load only on acceptance, so they hold between transactions
  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= bus.req_wr;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
      if (ack_hit) begin
        rdata_q <= wr_q ? 32'd0 : bus.reg_rdata;
      end else if (timeout_hit) begin
        rdata_q <= TO_RDATA;
      end
    end
  end

  assign bus.reg_wr    = wr_q;
  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_be    = be_q;
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_reg_bus_initiator.sv
// tb/tb_reg_bus_initiator.sv - directed self-checking bench for reg_bus_initiator
module tb_reg_bus_initiator;
  logic mclk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cs_run = 0;
  int   cs_len = 0;
  int   low_run = 0;
  int   last_gap = 0;
  int   rsp_seen = 0;

  reg_bus_initiator_if bus ();

  reg_bus_initiator #(
    .TIMEOUT_CYC (8),
    .TO_RDATA    (32'hFFFF_FFFF)
  ) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) begin
    if (bus.reg_cs) begin
      if (cs_run == 0) last_gap = low_run;
      cs_run  = cs_run + 1;
      low_run = 0;
    end else begin
      if (cs_run != 0) cs_len = cs_run;
      cs_run  = 0;
      low_run = low_run + 1;
    end
    if (bus.rsp_valid) rsp_seen = rsp_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic samp();
    @(negedge mclk);
    #1;
  endtask

  task automatic present(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
  endtask

  task automatic txn(input string tag, input logic wr, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int ack_dly,
                     input logic [31:0] ack_data, input logic [31:0] exp_rdata, input int stall);
    logic bad;
    bad = 1'b0;
    present(wr, addr, wdata, be);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i <= ack_dly; i++) begin
      if (i == ack_dly) begin
        bus.reg_ack   = 1'b1;
        bus.reg_rdata = ack_data;
      end
      samp();
      if (bus.reg_cs !== 1'b1 || bus.reg_wr !== wr || bus.reg_addr !== addr ||
          bus.reg_be !== be || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
          (wr && bus.reg_wdata !== wdata))
        bad = 1'b1;
      tick();
    end
    bus.reg_ack   = 1'b0;
    bus.reg_rdata = 32'h0BAD_F00D;
    check({tag, " access fields"}, {31'd0, bad}, 32'd0);
    samp();
    check({tag, " cs low"}, {31'd0, bus.reg_cs}, 32'd0);
    check({tag, " rsp valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({tag, " rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, " err"}, {31'd0, bus.rsp_err}, 32'd0);
    check({tag, " cs len"}, cs_len, ack_dly + 1);
    for (int i = 0; i < stall; i++) begin
      tick();
      samp();
      check({tag, " held valid"}, {31'd0, bus.rsp_valid}, 32'd1);
      check({tag, " held rdata"}, bus.rsp_rdata, exp_rdata);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    samp();
    check({tag, " rsp done"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, " req ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 32'h0;
    bus.req_be    = 4'h0;
    bus.rsp_ready = 1'b0;
    bus.reg_rdata = 32'h0;
    bus.reg_ack   = 1'b0;
    tick();
    tick();
    samp();
    check("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst reg_cs", {31'd0, bus.reg_cs}, 32'd0);
    check("rst reg_fields", {bus.reg_wr, bus.reg_addr, bus.reg_be, 19'd0},
          32'd0);
    check("rst reg_wdata", bus.reg_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // reset with a transaction in flight
    present(1'b1, 8'h33, 32'hCAFE_0001, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    samp();
    check("abort cs high", {31'd0, bus.reg_cs}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    samp();
    check("abort cs", {31'd0, bus.reg_cs}, 32'd0);
    check("abort rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("abort req_ready", {31'd0, bus.req_ready}, 32'd1);
    seen = rsp_seen;
    bus.reg_ack = 1'b1;
    tick();
    bus.reg_ack = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    samp();
    check("abort no rsp", rsp_seen, seen);

    txn("read", 1'b0, 8'h04, 32'h0, 4'hF, 1, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 0);
    txn("minlat", 1'b0, 8'h08, 32'h0, 4'hF, 0, 32'h0000_1111, 32'h0000_1111, 0);

    // stray ack in IDLE
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h7777_7777;
    tick();
    bus.reg_ack = 1'b0;
    samp();
    check("stray idle ready", {31'd0, bus.req_ready}, 32'd1);
    check("stray idle cs", {31'd0, bus.reg_cs}, 32'd0);
    check("stray idle valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("stray idle rdata", bus.rsp_rdata, 32'h0000_1111);

    txn("write", 1'b1, 8'h10, 32'h1234_5678, 4'b0011, 5, 32'hDEAD_BEEF, 32'h0, 2);
    samp();
    check("idle hold addr", {24'd0, bus.reg_addr}, 32'h10);
    check("idle hold wdata", bus.reg_wdata, 32'h1234_5678);

    // back-to-back with response backpressure
    present(1'b0, 8'h20, 32'h0, 4'hF);
    tick();
    present(1'b1, 8'h21, 32'h5555_AAAA, 4'b1100);
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h0102_0304;
    samp();
    check("b2b a addr", {24'd0, bus.reg_addr}, 32'h20);
    check("b2b wait ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    bus.reg_ack = 1'b0;
    samp();
    check("b2b a rdata", bus.rsp_rdata, 32'h0102_0304);
    // stray ack while the response waits
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h9999_9999;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.reg_ack = 1'b0;
      samp();
      check("b2b held valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("b2b held rdata", bus.rsp_rdata, 32'h0102_0304);
      check("b2b held cs", {31'd0, bus.reg_cs}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    samp();
    check("b2b hs valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("b2b hs cs", {31'd0, bus.reg_cs}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'hEEEE_EEEE;
    samp();
    check("b2b b cs", {31'd0, bus.reg_cs}, 32'd1);
    check("b2b b addr", {24'd0, bus.reg_addr}, 32'h21);
    check("b2b gap", last_gap, 5);
    tick();
    bus.reg_ack = 1'b0;
    samp();
    check("b2b b rdata", bus.rsp_rdata, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

`ifdef REG_INIT_TIMEOUT_EN
    present(1'b0, 8'h30, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) tick();
    samp();
    check("to valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("to err", {31'd0, bus.rsp_err}, 32'd1);
    check("to rdata", bus.rsp_rdata, 32'hFFFF_FFFF);
    check("to cs len", cs_len, 8);
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h1111_2222;
    tick();
    bus.reg_ack = 1'b0;
    samp();
    check("to late err", {31'd0, bus.rsp_err}, 32'd1);
    check("to late rdata", bus.rsp_rdata, 32'hFFFF_FFFF);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    tick();

    present(1'b0, 8'h31, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h3C3C_C3C3;
    tick();
    bus.reg_ack = 1'b0;
    samp();
    check("tie valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("tie err", {31'd0, bus.rsp_err}, 32'd0);
    check("tie rdata", bus.rsp_rdata, 32'h3C3C_C3C3);
    check("tie cs len", cs_len, 8);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
`else
    present(1'b0, 8'h30, 32'h0, 4'hF);
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    samp();
    check("nto cs", {31'd0, bus.reg_cs}, 32'd1);
    check("nto valid", {31'd0, bus.rsp_valid}, 32'd0);
    bus.reg_ack   = 1'b1;
    bus.reg_rdata = 32'h3C3C_C3C3;
    tick();
    bus.reg_ack = 1'b0;
    samp();
    check("nto err", {31'd0, bus.rsp_err}, 32'd0);
    check("nto rdata", bus.rsp_rdata, 32'h3C3C_C3C3);
    check("nto cs len", cs_len, 21);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
`endif
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_bus_initiator.md
# reg_bus_initiator

Initiator for the 8-bit-address / 32-bit-data register bus served by the global-config responder (`reg_cs`/`reg_wr`/`reg_addr`/`reg_wdata`/`reg_be` out, `reg_rdata`/`reg_ack` back). It accepts single register requests on a valid/ready port from a host-side master, such as the UART master or a Wishbone bridge. It runs exactly one bus transaction per request and returns read data and status on a valid/ready response port. One outstanding transaction at a time; an optional timeout converts a missing `reg_ack` into an error response.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 64: cycles `reg_cs` may stay high without `reg_ack` before an error response; legal range 1..255.
- `TO_RDATA`, default 32'hFFFF_FFFF: `rsp_rdata` value returned on timeout.

Ports:
- `mclk`  in  1  block clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  register address.
- `req_wdata`  in  32  write data.
- `req_be`  in  4  byte enables.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed when high together with `rsp_valid`.
- `rsp_rdata`  out  32  read data; 0 for writes; `TO_RDATA` on timeout.
- `rsp_err`  out  1  1 = timeout.
- `reg_cs`  out  1  bus chip select.
- `reg_wr`  out  1  bus write strobe.
- `reg_addr`  out  8  bus address.
- `reg_wdata`  out  32  bus write data.
- `reg_be`  out  4  bus byte enables.
- `reg_rdata`  in  32  responder read data, valid with `reg_ack`.
- `reg_ack`  in  1  responder completion, single-cycle pulse.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: `req_ready`=1. On `req_valid`, register `req_wr`/`req_addr`/`req_wdata`/`req_be` onto the `reg_*` outputs, set `reg_cs`=1, go to ACCESS.
  - ACCESS: `reg_cs`=1 and all `reg_*` outputs stable. On `reg_ack`, capture `reg_rdata` for a read or 0 for a write, clear `rsp_err`, drop `reg_cs`, go to RESP.
  - RESP: `rsp_valid`=1 and response fields stable. On `rsp_ready`, go to IDLE.
- `req_ready`=0 in ACCESS and RESP. A request presented there waits; it is not dropped.
- `reg_ack` outside ACCESS is ignored and does not change state or outputs.
- `reg_wr`, `reg_addr`, `reg_wdata` and `reg_be` hold their last value when `reg_cs`=0.
- Timeout counter, 8 bits:
  - Cleared on entry to ACCESS; increments each ACCESS cycle without `reg_ack`.
  - When the counter reaches `TIMEOUT_CYC`-1 with no ack: `rsp_err`=1, `rsp_rdata`=`TO_RDATA`, drop `reg_cs`, go to RESP.
  - `reg_ack` in the same cycle as timeout expiry: ack wins and `rsp_err`=0.
- Reset values, all outputs: `req_ready`=1 (IDLE), `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `reg_cs`=0, `reg_wr`=0, `reg_addr`=0, `reg_wdata`=0, `reg_be`=0; timeout counter 0.
- Reset mid-transaction aborts it: `reg_cs` low on the next edge and no response is produced.

## Timing
- Request accepted at edge N → `reg_cs`=1 from after edge N.
- `reg_ack` sampled high at edge M → `reg_cs`=0 and `rsp_valid`=1 after edge M.
- Minimum request-to-response latency is 2 cycles, with ack on the first ACCESS cycle.
- `rsp_valid` + `rsp_ready` at edge P → `req_ready`=1 after P. The next `reg_cs` rises no earlier than after edge P+1.
- `reg_cs` is therefore low for at least 2 cycles between transactions, which guarantees the responder sees a fresh cs edge.
- Back-to-back throughput: one transaction per 3 cycles minimum.
- With timeout enabled, `reg_cs` is high for at most `TIMEOUT_CYC` cycles.

## Configuration
- `REG_INIT_TIMEOUT_EN` defined:
  - Timeout counter and error path are present, as described under Operation.
  - `TIMEOUT_CYC` and `TO_RDATA` are in effect.
- Not defined:
  - No counter; ACCESS waits for `reg_ack` indefinitely.
  - `rsp_err` is tied to 0.
  - `TIMEOUT_CYC` and `TO_RDATA` are unused.

## Test plan
- Reset check: assert `reset` with a transaction in flight → after the next edge `reg_cs`=0, `rsp_valid`=0, `req_ready`=1, and no response is emitted afterwards.
- Read: request read, addr 8'h04; responder acks 1 cycle after cs with rdata 32'hA5A5_0F0F → `rsp_valid` follows the ack edge with `rsp_rdata`=32'hA5A5_0F0F and `rsp_err`=0; `reg_wr`=0 throughout.
- Write with stall: request write, addr 8'h10, wdata 32'h1234_5678, be 4'b0011; ack delayed 5 cycles → `reg_cs` high exactly 6 cycles with fields stable; response carries `rsp_rdata`=0.
- Back-to-back with backpressure: two queued requests; `rsp_ready` low for 3 cycles on the first response → `rsp_valid` and its data held, second `reg_cs` absent until 1 cycle after the handshake, and cs low ≥2 cycles between transactions.
- Timeout (macro defined, `TIMEOUT_CYC`=8): no ack → after 8 cs-high cycles `rsp_err`=1, `rsp_rdata`=32'hFFFF_FFFF; a late ack is ignored. Ack coincident with expiry gives `rsp_err`=0 with real data.
- Stray ack: pulse `reg_ack` in IDLE and in RESP → no state or output change.
